// File: rtl/amiga_video_pattern_gen_pkg.sv
// PAL timing constants, pattern encoding and colour-bar helpers shared by the
// pattern generator and the sampler bench.
package amiga_video_pattern_gen_pkg;

    localparam int unsigned H_TOTAL     = 908;
    localparam int unsigned H_SYNC      = 67;
    localparam int unsigned H_ACT_START = 160;
    localparam int unsigned H_ACT       = 640;
    localparam int unsigned V_LONG      = 313;
    localparam int unsigned V_SHORT     = 312;
    localparam int unsigned V_ACT_START = 26;
    localparam int unsigned V_ACT       = 256;
    localparam int unsigned VS_LINES    = 3;
    localparam int unsigned BAR_W       = 80;

    typedef logic [11:0] rgb_t;

    typedef enum logic [1:0] {
        PatSolid  = 2'd0,
        PatBars   = 2'd1,
        PatParity = 2'd2,
        PatRamp   = 2'd3
    } pattern_e;

    // Bar number for active x; compare chain instead of a divider.
    function automatic logic [2:0] bar_index(input logic [9:0] x);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (x >= 10'(i * BAR_W)) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        unique case (idx)
            3'd0: c = 12'hFFF;
            3'd1: c = 12'hFF0;
            3'd2: c = 12'h0FF;
            3'd3: c = 12'h0F0;
            3'd4: c = 12'hF0F;
            3'd5: c = 12'hF00;
            3'd6: c = 12'h00F;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/amiga_video_pattern_gen_if.sv
// Amiga video port bundle: pattern controls in, CSYNC/RGB and field status out.
interface amiga_video_pattern_gen_if;
    import amiga_video_pattern_gen_pkg::*;

    logic       interlace_in;
    logic [1:0] pattern_sel;
    rgb_t       solid_rgb;
    logic       csync_n;
    rgb_t       am_rgb;
    logic       field_no;
    logic       interlaced;
    logic       sof;

    // Generator side.
    modport master (
        input  interlace_in, pattern_sel, solid_rgb,
        output csync_n, am_rgb, field_no, interlaced, sof
    );

    // Receiver / stimulus side.
    modport slave (
        output interlace_in, pattern_sel, solid_rgb,
        input  csync_n, am_rgb, field_no, interlaced, sof
    );
endinterface

// File: rtl/amiga_sync_counter.sv
// Line/pixel counters, per-field latches and vsync-window / active decode.
// Field-boundary values are presented combinationally on the (0,0) clock so
// the outputs registered from that clock already belong to the new field.
module amiga_sync_counter
    import amiga_video_pattern_gen_pkg::*;
#(
    parameter int unsigned VLong     = V_LONG,
    parameter int unsigned VShort    = V_SHORT,
    parameter int unsigned VActStart = V_ACT_START,
    parameter int unsigned VAct      = V_ACT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       interlace_i,
    input  logic [1:0] pattern_sel_i,
    output logic [9:0] hcnt_o,
    output logic [8:0] vcnt_o,
    output logic       field_no_o,
    output logic       interlaced_o,
    output pattern_e   pattern_o,
    output logic       sof_o,
    output logic       vs_win_o,
    output logic       active_o
);
    localparam logic [9:0] HLast      = 10'(H_TOTAL - 1);
    localparam logic [9:0] HHalf      = 10'(H_TOTAL / 2);
    localparam logic [9:0] HActLo     = 10'(H_ACT_START);
    localparam logic [9:0] HActHi     = 10'(H_ACT_START + H_ACT);
    localparam logic [8:0] VLongLast  = 9'(VLong - 1);
    localparam logic [8:0] VShortLast = 9'(VShort - 1);
    localparam logic [8:0] VsLines    = 9'(VS_LINES);
    localparam logic [8:0] VActLo     = 9'(VActStart);
    localparam logic [8:0] VActHi     = 9'(VActStart + VAct);

    logic [9:0] hcnt_q, hcnt_d;
    logic [8:0] vcnt_q, vcnt_d;
    logic       field_q, field_cur;
    logic       ilace_q, ilace_cur;
    pattern_e   pat_q, pat_cur;
    logic       first_q;
    logic       at_start;

    // Field-boundary latching and counter next-state.
    always_comb begin
        at_start  = (hcnt_q == 10'd0) && (vcnt_q == 9'd0);
        field_cur = field_q;
        ilace_cur = ilace_q;
        pat_cur   = pat_q;
        if (at_start) begin
            ilace_cur = interlace_i;
            pat_cur   = pattern_e'(pattern_sel_i);
            // Reset always restarts in the long field.
            field_cur = (interlace_i && !first_q) ? ~field_q : 1'b0;
        end
        hcnt_d = hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == HLast) begin
            hcnt_d = 10'd0;
            vcnt_d = (vcnt_q == (field_cur ? VShortLast : VLongLast)) ? 9'd0 : vcnt_q + 9'd1;
        end
    end

    // Vsync window (offset half a line in the short field) and active area.
    always_comb begin
        if (!field_cur) begin
            vs_win_o = vcnt_q < VsLines;
        end else begin
            vs_win_o = ((vcnt_q == 9'd0) && (hcnt_q >= HHalf)) ||
                       ((vcnt_q != 9'd0) && (vcnt_q < VsLines)) ||
                       ((vcnt_q == VsLines) && (hcnt_q < HHalf));
        end
        active_o = (hcnt_q >= HActLo) && (hcnt_q < HActHi) &&
                   (vcnt_q >= VActLo) && (vcnt_q < VActHi);
    end

    // Counter and field-latch state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hcnt_q  <= 10'd0;
            vcnt_q  <= 9'd0;
            field_q <= 1'b0;
            ilace_q <= 1'b0;
            pat_q   <= PatSolid;
            first_q <= 1'b1;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            field_q <= field_cur;
            ilace_q <= ilace_cur;
            pat_q   <= pat_cur;
            first_q <= 1'b0;
        end
    end

    assign hcnt_o       = hcnt_q;
    assign vcnt_o       = vcnt_q;
    assign field_no_o   = field_cur;
    assign interlaced_o = ilace_cur;
    assign pattern_o    = pat_cur;
    assign sof_o        = at_start;

endmodule

// File: rtl/amiga_video_pattern_gen.sv
// PAL Amiga video-port source: composite sync plus 12-bit RGB test patterns.
// Every output is registered once from the counter state so sync and pixels
// stay aligned.
module amiga_video_pattern_gen
    import amiga_video_pattern_gen_pkg::*;
#(
    parameter int unsigned VLong     = V_LONG,
    parameter int unsigned VShort    = V_SHORT,
    parameter int unsigned VActStart = V_ACT_START,
    parameter int unsigned VAct      = V_ACT
) (
    input logic                        clk,
    input logic                        reset_n,
    amiga_video_pattern_gen_if.master  vid
);
    localparam logic [9:0] HHalf   = 10'(H_TOTAL / 2);
    localparam logic [9:0] HSync   = 10'(H_SYNC);
    localparam logic [9:0] BroadLo = 10'(H_TOTAL / 2 - H_SYNC);
    localparam logic [9:0] HActLo  = 10'(H_ACT_START);
    localparam logic [8:0] VActLo  = 9'(VActStart);

    logic [9:0] hcnt, hmod, x;
    logic [8:0] vcnt;
    logic [3:0] y_hi;
    logic       field_no, interlaced, sof, vs_win, active;
    pattern_e   pattern;
    logic       csync_d, csync_q;
    rgb_t       rgb_d, rgb_q;
    logic       field_q, ilace_q, sof_q;

    amiga_sync_counter #(
        .VLong     (VLong),
        .VShort    (VShort),
        .VActStart (VActStart),
        .VAct      (VAct)
    ) u_sync_counter (
        .clk           (clk),
        .reset_n       (reset_n),
        .interlace_i   (vid.interlace_in),
        .pattern_sel_i (vid.pattern_sel),
        .hcnt_o        (hcnt),
        .vcnt_o        (vcnt),
        .field_no_o    (field_no),
        .interlaced_o  (interlaced),
        .pattern_o     (pattern),
        .sof_o         (sof),
        .vs_win_o      (vs_win),
        .active_o      (active)
    );

    // Sync level and pixel colour for the current counter state.
    always_comb begin
        hmod    = (hcnt >= HHalf) ? hcnt - HHalf : hcnt;
        csync_d = vs_win ? (hmod >= BroadLo) : (hcnt >= HSync);
        x       = hcnt - HActLo;
        y_hi    = 4'((vcnt - VActLo) >> 4);
        rgb_d   = 12'h000;
        if (active) begin
            unique case (pattern)
                PatSolid:  rgb_d = vid.solid_rgb;
                PatBars:   rgb_d = bar_colour(bar_index(x));
                PatParity: rgb_d = (vcnt[0] ^ field_no) ? 12'hFFF : 12'h000;
                PatRamp:   rgb_d = {x[7:4], y_hi, x[3:0]};
            endcase
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            csync_q <= 1'b1;
            rgb_q   <= 12'h000;
            field_q <= 1'b0;
            ilace_q <= 1'b0;
            sof_q   <= 1'b0;
        end else begin
            csync_q <= csync_d;
            rgb_q   <= rgb_d;
            field_q <= field_no;
            ilace_q <= interlaced;
            sof_q   <= sof;
        end
    end

    assign vid.csync_n    = csync_q;
    assign vid.am_rgb     = rgb_q;
    assign vid.field_no   = field_q;
    assign vid.interlaced = ilace_q;
    assign vid.sof        = sof_q;

endmodule
